// File: rtl/vip_pkg.sv
// Shared types and default timing for the VIP stream generator chain.
package vip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  typedef logic [7:0] pixel_t;

  localparam int unsigned DEF_H_ACTIVE  = 640;
  localparam int unsigned DEF_V_ACTIVE  = 480;
  localparam int unsigned DEF_H_BLANK   = 160;
  localparam int unsigned DEF_VSYNC_LEN = 2;
  localparam int unsigned DEF_V_BACK    = 2;
  localparam int unsigned DEF_V_FRONT   = 2;
  localparam int unsigned DEF_CLKEN_DIV = 1;

endpackage

// File: rtl/vip_timing_cnt.sv
// Horizontal/line counter pair: end-of-line and end-of-state strobes plus the
// per-pixel clken divider. Counters sit at zero while run is low.
module vip_timing_cnt
  import vip_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_BLANK   = DEF_H_BLANK,
  parameter int unsigned CLKEN_DIV = DEF_CLKEN_DIV,
  parameter int unsigned H_W       = $clog2(H_ACTIVE*CLKEN_DIV + H_BLANK),
  parameter int unsigned LINE_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [LINE_W-1:0] state_lines,
  output logic [H_W-1:0]    h_cnt,
  output logic [LINE_W-1:0] line_cnt,
  output logic              eol_c,
  output logic              eos_c,
  output logic              pix_tick_c
);

  localparam int unsigned H_ACT_CLKS = H_ACTIVE*CLKEN_DIV;
  localparam int unsigned LINE_LEN   = H_ACT_CLKS + H_BLANK;
  localparam int unsigned DIV_W      = (CLKEN_DIV > 1) ? $clog2(CLKEN_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;

  assign eol_c      = run && (h_cnt == H_W'(LINE_LEN - 1));
  assign eos_c      = eol_c && (line_cnt == (state_lines - LINE_W'(1)));
  assign pix_tick_c = run && (h_cnt < H_W'(H_ACT_CLKS)) && (div_cnt == '0);

  // Divider restarts every line so the first pixel lands on h_cnt == 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt    <= '0;
      line_cnt <= '0;
      div_cnt  <= '0;
    end else if (!run) begin
      h_cnt    <= '0;
      line_cnt <= '0;
      div_cnt  <= '0;
    end else begin
      h_cnt   <= eol_c ? '0 : h_cnt + H_W'(1);
      div_cnt <= (eol_c || (div_cnt == DIV_W'(CLKEN_DIV - 1))) ? '0 : div_cnt + DIV_W'(1);
      if (eos_c)
        line_cnt <= '0;
      else if (eol_c)
        line_cnt <= line_cnt + LINE_W'(1);
    end
  end

endmodule

// File: rtl/vip_frame_stream_gen.sv
// Grey-frame video source: walks a stored frame and emits vsync/href/clken/Y.
// Define VIP_TEST_PATTERN_EN to replace memory pixels with a scrolling ramp.
module vip_frame_stream_gen
  import vip_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned H_BLANK   = DEF_H_BLANK,
  parameter int unsigned VSYNC_LEN = DEF_VSYNC_LEN,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned CLKEN_DIV = DEF_CLKEN_DIV,
  parameter int unsigned ADDR_W    = $clog2(H_ACTIVE*V_ACTIVE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [7:0]        post_img_Y,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned H_ACT_CLKS = H_ACTIVE*CLKEN_DIV;
  localparam int unsigned LINE_LEN   = H_ACT_CLKS + H_BLANK;
  localparam int unsigned H_W        = $clog2(LINE_LEN);
  localparam int unsigned LINE_W     = $clog2(VSYNC_LEN + V_BACK + V_ACTIVE + V_FRONT + 1);

  state_t            state, state_nxt;
  logic [LINE_W-1:0] state_lines_c;
  logic [H_W-1:0]    h_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic              eol_c, eos_c, pix_tick_c;
  logic              frame_end_c, frame_start_c;
  logic              vsync_i, href_i, tick_i;
  pixel_t            pix_src, y_q;

  vip_timing_cnt #(
    .H_ACTIVE  (H_ACTIVE),
    .H_BLANK   (H_BLANK),
    .CLKEN_DIV (CLKEN_DIV),
    .H_W       (H_W),
    .LINE_W    (LINE_W)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .run         (state != ST_IDLE),
    .state_lines (state_lines_c),
    .h_cnt       (h_cnt),
    .line_cnt    (line_cnt),
    .eol_c       (eol_c),
    .eos_c       (eos_c),
    .pix_tick_c  (pix_tick_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Zero-length back/front porches are skipped; enable is only looked at on frame boundaries.
  always_comb begin
    state_nxt     = state;
    frame_end_c   = 1'b0;
    state_lines_c = LINE_W'(1);
    case (state)
      ST_IDLE: begin
        if (enable)
          state_nxt = ST_VSYNC;
      end
      ST_VSYNC: begin
        state_lines_c = LINE_W'(VSYNC_LEN);
        if (eos_c)
          state_nxt = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
      end
      ST_VBACK: begin
        state_lines_c = LINE_W'(V_BACK);
        if (eos_c)
          state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        state_lines_c = LINE_W'(V_ACTIVE);
        if (eos_c) begin
          if (V_FRONT > 0) begin
            state_nxt = ST_VFRONT;
          end else begin
            frame_end_c = 1'b1;
            state_nxt   = enable ? ST_VSYNC : ST_IDLE;
          end
        end
      end
      ST_VFRONT: begin
        state_lines_c = LINE_W'(V_FRONT);
        if (eos_c) begin
          frame_end_c = 1'b1;
          state_nxt   = enable ? ST_VSYNC : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign frame_start_c = (state == ST_VSYNC) && (line_cnt == '0) && (h_cnt == '0);
  assign vsync_i       = (state == ST_VSYNC);
  assign href_i        = (state == ST_ACTIVE) && (h_cnt < H_W'(H_ACT_CLKS));
  assign tick_i        = (state == ST_ACTIVE) && pix_tick_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_addr <= '0;
    else if (frame_start_c)
      rd_addr <= '0;
    else if (tick_i)
      rd_addr <= rd_addr + ADDR_W'(1);
  end

`ifdef VIP_TEST_PATTERN_EN
  localparam int unsigned COL_W = $clog2(H_ACTIVE + 1);

  logic [COL_W-1:0] col_cnt;
  pixel_t           pat_q;
  logic             unused_rd_data;

  // Ramp value is registered at the internal tick so it lines up like RAM read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
      pat_q   <= '0;
    end else begin
      if (eol_c)
        col_cnt <= '0;
      else if (tick_i)
        col_cnt <= col_cnt + COL_W'(1);
      if (tick_i)
        pat_q <= 8'(col_cnt) + 8'(line_cnt) + frame_cnt[7:0];
    end
  end

  assign rd_en          = 1'b0;
  assign pix_src        = pat_q;
  assign unused_rd_data = ^rd_data;
`else
  assign rd_en   = tick_i;
  assign pix_src = rd_data;
`endif

  // Output stage runs one clk behind the internal strobes to match the RAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      y_q              <= '0;
      frame_done       <= 1'b0;
      frame_cnt        <= '0;
    end else begin
      post_frame_vsync <= vsync_i;
      post_frame_href  <= href_i;
      post_frame_clken <= tick_i;
      frame_done       <= frame_end_c;
      if (frame_end_c)
        frame_cnt <= frame_cnt + 16'd1;
      if (post_frame_clken)
        y_q <= pix_src;
    end
  end

  // Read data is only valid on the clken cycle itself; y_q holds it until the next pixel.
  assign post_img_Y = !post_frame_href ? 8'd0 : (post_frame_clken ? pix_src : y_q);

endmodule

// File: tb/tb_vip_frame_stream_gen.sv
// Directed bench for vip_frame_stream_gen with a pixel scoreboard; small frame
// geometry, plus a second instance with a 2-clk pixel divider.
`timescale 1ns/1ps
module tb_vip_frame_stream_gen;
  import vip_pkg::*;

  localparam int unsigned HA = 4;
  localparam int unsigned VA = 3;
  localparam int unsigned HB = 2;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 1;
  localparam int unsigned VF = 1;
  localparam int unsigned AW = $clog2(HA*VA);

`ifdef VIP_TEST_PATTERN_EN
  localparam int ROW_STRIDE = 1;
  localparam int BASE       = 0;
  localparam int FC_GAIN    = 1;
  localparam int RD_FRAME   = 0;
`else
  localparam int ROW_STRIDE = HA;
  localparam int BASE       = 10;
  localparam int FC_GAIN    = 0;
  localparam int RD_FRAME   = HA*VA;
`endif

  logic          clk = 1'b0;
  logic          rst, enable, rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          vsync, href, clken, frame_done;
  logic [7:0]    y;
  logic [15:0]   frame_cnt;

  logic          rst2, enable2, rd_en2;
  logic [AW-1:0] rd_addr2;
  logic [7:0]    rd_data2;
  logic          vsync2, href2, clken2, frame_done2;
  logic [7:0]    y2, y2_prev;
  logic [15:0]   frame_cnt2;

  pixel_t q1[$];
  pixel_t q2[$];
  int     checks   = 0;
  int     failures = 0;

  always #5 clk = ~clk;

  vip_frame_stream_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LEN(VS),
    .V_BACK(VB), .V_FRONT(VF), .CLKEN_DIV(1), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .post_frame_vsync(vsync), .post_frame_href(href),
    .post_frame_clken(clken), .post_img_Y(y), .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  vip_frame_stream_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LEN(VS),
    .V_BACK(VB), .V_FRONT(VF), .CLKEN_DIV(2), .ADDR_W(AW)
  ) dut2 (
    .clk(clk), .rst(rst2), .enable(enable2), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .rd_data(rd_data2), .post_frame_vsync(vsync2), .post_frame_href(href2),
    .post_frame_clken(clken2), .post_img_Y(y2), .frame_done(frame_done2),
    .frame_cnt(frame_cnt2)
  );

  // Pixel memory: pixel = addr + 10, one clk read latency.
  always @(posedge clk) begin
    if (rd_en)  rd_data  <= 8'(32'(rd_addr) + 10);
    if (rd_en2) rd_data2 <= 8'(32'(rd_addr2) + 10);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pixel_t exp_pix(input int r, input int c, input logic [15:0] fc);
    return 8'(r*ROW_STRIDE + c + BASE + FC_GAIN*int'(fc[7:0]));
  endfunction

  function automatic logic href_exp(input int i, input int div);
    int l = (HA*div + HB);
    int s = (VS + VB)*l;
    return (i >= s) && (i < s + VA*l) && (((i - s) % l) < HA*div);
  endfunction

  // Scoreboard and stream invariants, sampled mid-cycle.
  always @(negedge clk) begin
    pixel_t e;
    chk("href_vsync_excl", 32'(href & vsync), 32'd0);
    chk("clken_in_href", 32'(clken & ~href), 32'd0);
    if (!href) chk("y_zero_blank", 32'(y), 32'd0);
    if (!rst && clken) begin
      if (q1.size() == 0) begin
        chk("y1_extra_pixel", 32'(q1.size()), 32'd1);
      end else begin
        e = q1.pop_front();
        chk("y1_stream", 32'(y), 32'(e));
      end
    end
    chk("href2_vsync2_excl", 32'(href2 & vsync2), 32'd0);
    chk("clken2_in_href2", 32'(clken2 & ~href2), 32'd0);
    if (!href2) chk("y2_zero_blank", 32'(y2), 32'd0);
    if (href2 && !clken2) chk("y2_hold", 32'(y2), 32'(y2_prev));
    if (!rst2 && clken2) begin
      if (q2.size() == 0) begin
        chk("y2_extra_pixel", 32'(q2.size()), 32'd1);
      end else begin
        e = q2.pop_front();
        chk("y2_stream", 32'(y2), 32'(e));
      end
    end
    y2_prev = y2;
  end

  task automatic all_zero(input string tag);
    chk({tag, "_vsync"}, 32'(vsync), 32'd0);
    chk({tag, "_href"}, 32'(href), 32'd0);
    chk({tag, "_clken"}, 32'(clken), 32'd0);
    chk({tag, "_y"}, 32'(y), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  // One full 42-clk frame on dut, index 0 = first vsync clk.
  task automatic run_frame(input string tag, input int drop_at, input logic [15:0] fc0);
    logic        vs[42], hr[42], ce[42], fd[42], re[42];
    logic [15:0] fc[42];
    logic [AW-1:0] ra[42];
    int bad_vs = 0, bad_hr = 0, bad_ce = 0, bad_fd = 0, bad_fc = 0, bad_re = 0, n_re = 0, first_re = -1;
    for (int r = 0; r < int'(VA); r++)
      for (int c = 0; c < int'(HA); c++)
        q1.push_back(exp_pix(r, c, fc0));
    for (int w = 0; w < 6 && !vsync; w++) tick();
    chk({tag, "_vsync_start"}, 32'(vsync), 32'd1);
    for (int i = 0; i < 42; i++) begin
      if (i > 0) tick();
      vs[i] = vsync; hr[i] = href; ce[i] = clken; fd[i] = frame_done;
      re[i] = rd_en; ra[i] = rd_addr; fc[i] = frame_cnt;
      if (i == drop_at) enable = 1'b0;
    end
    for (int i = 0; i < 42; i++) begin
      if (vs[i] !== (i < 12)) bad_vs++;
      if (hr[i] !== href_exp(i, 1)) bad_hr++;
      if (ce[i] !== href_exp(i, 1)) bad_ce++;
      if (fd[i] !== (i == 41)) bad_fd++;
      if (fc[i] !== ((i == 41) ? 16'(fc0 + 16'd1) : fc0)) bad_fc++;
      if (RD_FRAME != 0 && i < 41 && re[i] !== href_exp(i + 1, 1)) bad_re++;
      if (re[i] === 1'b1) begin
        n_re++;
        if (first_re < 0) first_re = i;
      end
    end
    chk({tag, "_vsync_shape"}, 32'(bad_vs), 32'd0);
    chk({tag, "_href_shape"}, 32'(bad_hr), 32'd0);
    chk({tag, "_clken_shape"}, 32'(bad_ce), 32'd0);
    chk({tag, "_frame_done"}, 32'(bad_fd), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(bad_fc), 32'd0);
    chk({tag, "_rd_en_timing"}, 32'(bad_re), 32'd0);
    chk({tag, "_rd_en_count"}, 32'(n_re), 32'(RD_FRAME));
    if (first_re >= 0) chk({tag, "_rd_addr_first"}, 32'(ra[first_re]), 32'd0);
    chk({tag, "_pixels_left"}, 32'(q1.size()), 32'd0);
  endtask

  initial begin
    int n_vs, n_fd, bad;
    logic vs2[70], hr2[70], ce2[70], fd2[70];
    rst = 1'b1; rst2 = 1'b1; enable = 1'b0; enable2 = 1'b0; y2_prev = '0;
    repeat (3) tick();
    all_zero("reset");
    rst = 1'b0; rst2 = 1'b0;
    repeat (2) tick();
    chk("idle_vsync", 32'(vsync), 32'd0);

    // Frame 1 then back-to-back frame 2, interrupted by reset mid-line.
    enable = 1'b1;
    run_frame("f1", -1, 16'd0);
    tick();
    chk("f2_vsync_back2back", 32'(vsync), 32'd1);
    for (int r = 0; r < int'(VA); r++)
      for (int c = 0; c < int'(HA); c++)
        q1.push_back(exp_pix(r, c, 16'd1));
    repeat (25) tick();
    chk("f2_clken_pre_rst", 32'(clken), 32'd1);
    chk("f2_y_pre_rst", 32'(y), 32'(exp_pix(1, 1, 16'd1)));
    #1 rst = 1'b1;
    #1;
    all_zero("midrst");
    q1.delete();
    repeat (2) tick();
    rst = 1'b0;

    // Restart after reset; enable dropped at clk 20, frame still completes.
    run_frame("f3", 19, 16'd0);
    n_vs = 0; n_fd = 0;
    repeat (30) begin
      tick();
      if (vsync) n_vs++;
      if (frame_done) n_fd++;
    end
    chk("idle_no_vsync", 32'(n_vs), 32'd0);
    chk("idle_no_frame_done", 32'(n_fd), 32'd0);
    chk("idle_frame_cnt", 32'(frame_cnt), 32'd1);

    // frame_cnt wrap.
    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    tick();
    chk("wrap_preset", 32'(frame_cnt), 32'h0000_FFFF);
    enable = 1'b1;
    run_frame("wrap", 0, 16'hFFFF);
    n_fd = 0;
    repeat (10) begin
      tick();
      if (frame_done) n_fd++;
    end
    chk("wrap_single_done", 32'(n_fd), 32'd0);
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

    // CLKEN_DIV=2 instance: 10-clk lines, 70-clk frame.
    for (int r = 0; r < int'(VA); r++)
      for (int c = 0; c < int'(HA); c++)
        q2.push_back(exp_pix(r, c, 16'd0));
    enable2 = 1'b1;
    for (int w = 0; w < 6 && !vsync2; w++) tick();
    chk("d2_vsync_start", 32'(vsync2), 32'd1);
    for (int i = 0; i < 70; i++) begin
      if (i > 0) tick();
      vs2[i] = vsync2; hr2[i] = href2; ce2[i] = clken2; fd2[i] = frame_done2;
      if (i == 0) enable2 = 1'b0;
    end
    bad = 0;
    for (int i = 0; i < 70; i++) if (vs2[i] !== (i < 20)) bad++;
    chk("d2_vsync_shape", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 70; i++) if (hr2[i] !== href_exp(i, 2)) bad++;
    chk("d2_href_shape", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 70; i++)
      if (ce2[i] !== (href_exp(i, 2) && (((i - 30) % 10) % 2 == 0))) bad++;
    chk("d2_clken_shape", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 70; i++) if (fd2[i] !== (i == 69)) bad++;
    chk("d2_frame_done", 32'(bad), 32'd0);
    chk("d2_frame_cnt", 32'(frame_cnt2), 32'd1);
    chk("d2_pixels_left", 32'(q2.size()), 32'd0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
